morse_decoder: RTL
==================

Name: morse_decoder

Overview:
- Receiver end of the lab Morse link. It samples a serial dot/dash line once per bit tick, measures mark and space run lengths, and rebuilds the symbol sequence.
- It maps the sequence back to the 3-bit letter code A–H (000–111) and pulses a valid or error strobe.
- It sits downstream of the Morse encoder and shares that block's tick rate divider.

Parameters:
- LETTER_GAP, 3: consecutive sampled zeros after a mark that end a letter.
- MAX_SYMBOLS, 4: maximum dots plus dashes per letter.
- RUN_W, 3: width of the run-length counters (saturating).

Ports:
- ClockIn  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- BitTick  in  1  one-cycle sample enable, one per Morse unit
- DotDashIn  in  1  serial line; 1 = tone unit, 0 = silent unit
- Letter  out  3  decoded letter code, held until the next valid
- LetterValid  out  1  one-cycle pulse, Letter just updated
- Error  out  1  one-cycle pulse, malformed or unknown code
- Busy  out  1  high while a letter is in progress (state != IDLE)

Behaviour:
- Reset is synchronous, active-high; clock is ClockIn.
  - On Reset: Letter=000, LetterValid=0, Error=0, Busy=0, state=IDLE, all counters and symbol registers cleared.
  - Reset has priority over everything, including a mid-letter decode; any partial letter is discarded and produces no pulse.
- State changes only on edges where BitTick=1. LetterValid and Error still clear on the next ClockIn edge regardless of BitTick.
- Unit encoding: dot = 1 unit of 1, dash = 3 units of 1, intra-letter gap = 1 unit of 0.
- Symbol register: dot=0, dash=1, first symbol in the MSB.
- States:
  - IDLE: sample 1 → MARK, markcnt=1. Sample 0 → stay.
  - MARK: sample 1 → markcnt+1. If markcnt would exceed 3 → Error pulse, → RECOVER.
  - MARK, sample 0: classify markcnt. 1 = dot, 3 = dash, 2 = Error → RECOVER.
    - On a valid symbol, append it and increment symcnt; → SPACE, spacecnt=1.
  - SPACE: sample 1 with symcnt==MAX_SYMBOLS → Error pulse, → RECOVER.
  - SPACE: sample 1 otherwise → MARK, markcnt=1.
  - SPACE: sample 0 → spacecnt+1. On reaching LETTER_GAP, look up (symcnt, symbols):
    - Match: Letter updated and LetterValid=1 on that same edge, i.e. the edge sampling the LETTER_GAP-th zero.
    - No match: Error=1.
    - Either way → IDLE, registers cleared.
  - RECOVER: wait for LETTER_GAP consecutive zeros, then → IDLE. Any 1 restarts the zero count.
- Lookup table (len:pattern → code):
  - A 2:01 → 000
  - B 4:1000 → 001
  - C 4:1010 → 010
  - D 3:100 → 011
  - E 1:0 → 100
  - F 4:0010 → 101
  - G 3:110 → 110
  - H 4:0000 → 111
  - Anything else → Error.
- Counters saturate; there is no wrap-around.
- LetterValid and Error are never high in the same cycle.

Optional Feature:
- Macro MORSE_DEC_TOLERANT_EN.
  - Defined: mark of 1 = dot, mark of 2–4 = dash; Error only when a mark exceeds 4.
  - Undefined: strict behaviour as above (1 = dot, 3 = dash, 2 or >3 = Error).

Decomposition:
- Package morse_pkg holds:
  - state enum (IDLE, MARK, SPACE, RECOVER)
  - letter code constants LTR_A..LTR_H
  - DOT/DASH symbol encoding
  - MAX_SYMBOLS default
- One sub-module: morse_pattern_lookup, purely combinational.
  - Inputs: symcnt, symbols. Outputs: code, match.
  - It is shared with the encoder's table for consistency.

Test Plan:
- A: BitTick every 4th cycle; DotDashIn per tick 1,0,1,1,1,0,0,0 → single LetterValid=1 with Letter=000 on the 8th tick edge; Error stays 0.
- H, then E, back to back: 1,0,1,0,1,0,1,0,0,0 then 1,0,0,0 → LetterValid with 111, then LetterValid with 100. Busy=0 between the two letters.
- Bad mark: 1,1,0,0,0 → Error pulse on the 3rd tick; enters RECOVER; returns to IDLE after 3 zeros; no LetterValid. With MORSE_DEC_TOLERANT_EN the same stream gives Letter=100 (E read as dash?). No: 2:1 = T is unmapped → Error at gap end.
- Five symbols: 1,0 repeated 5 times → Error on the 9th tick, the 5th mark start; Letter keeps its previous value.
- Reset mid-letter: send 1,1,1,0, assert Reset for 1 cycle, then 1,0,0,0 → only one LetterValid, Letter=100; no Error.
- Tick gating: BitTick=0 for 20 cycles while DotDashIn toggles every cycle → no state change; Busy=0, no pulses.

Source files
------------

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse receiver: decoder state encoding, the 3-bit
// letter codes A..H, the dot/dash symbol encoding and symbol-register sizing.
// Imported by morse_decoder and morse_pattern_lookup.
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARK    = 2'd1,
        SPACE   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    typedef logic [2:0] letter_t;

    localparam letter_t LTR_A = 3'b000;
    localparam letter_t LTR_B = 3'b001;
    localparam letter_t LTR_C = 3'b010;
    localparam letter_t LTR_D = 3'b011;
    localparam letter_t LTR_E = 3'b100;
    localparam letter_t LTR_F = 3'b101;
    localparam letter_t LTR_G = 3'b110;
    localparam letter_t LTR_H = 3'b111;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int MAX_SYMBOLS_DEF = 4;

    // Symbol register is left-aligned: first symbol in bit SYM_W-1.
    localparam int SYM_W = 4;
    localparam int CNT_W = 3;

endpackage

// File: rtl/morse_pattern_lookup.sv
// -----------------------------------------------------------------------------
// morse_pattern_lookup
// Purely combinational map from a received symbol sequence to a letter code.
// The same table backs the encoder, so both ends agree on the alphabet.
//
// Ports:
//   i_symcnt   in  CNT_W  number of symbols received (1..4)
//   i_symbols  in  SYM_W  symbols, first in MSB, unused low bits zero
//   o_code     out 3      letter code (LTR_A when no match)
//   o_match    out 1      1 when (i_symcnt, i_symbols) is a known letter
// -----------------------------------------------------------------------------
module morse_pattern_lookup
    import morse_pkg::*;
(
    input  logic [CNT_W-1:0] i_symcnt,
    input  logic [SYM_W-1:0] i_symbols,
    output letter_t          o_code,
    output logic             o_match
);

    always_comb begin
        o_code  = LTR_A;
        o_match = 1'b0;
        case ({i_symcnt, i_symbols})
            {3'd2, 4'b0100}: begin o_code = LTR_A; o_match = 1'b1; end
            {3'd4, 4'b1000}: begin o_code = LTR_B; o_match = 1'b1; end
            {3'd4, 4'b1010}: begin o_code = LTR_C; o_match = 1'b1; end
            {3'd3, 4'b1000}: begin o_code = LTR_D; o_match = 1'b1; end
            {3'd1, 4'b0000}: begin o_code = LTR_E; o_match = 1'b1; end
            {3'd4, 4'b0010}: begin o_code = LTR_F; o_match = 1'b1; end
            {3'd3, 4'b1100}: begin o_code = LTR_G; o_match = 1'b1; end
            {3'd4, 4'b0000}: begin o_code = LTR_H; o_match = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
// Morse link receiver. Samples DotDashIn on each BitTick, measures mark and
// space run lengths, rebuilds the dot/dash sequence and maps it to a letter
// code A..H. Pulses LetterValid on a decoded letter, Error on a malformed or
// unknown code.
//
// Build option: define MORSE_DEC_TOLERANT_EN to accept marks of 2..4 units as
// a dash (Error only above 4). Default build: 1 = dot, 3 = dash, else Error.
//
// Ports:
//   ClockIn      in  1  system clock
//   Reset        in  1  synchronous, active-high reset
//   BitTick      in  1  one-cycle sample enable, one per Morse unit
//   DotDashIn    in  1  serial line, 1 = tone unit
//   Letter       out 3  last decoded letter code, held until next valid
//   LetterValid  out 1  one-cycle pulse, Letter just updated
//   Error        out 1  one-cycle pulse, malformed or unknown code
//   Busy         out 1  high while a letter (or error recovery) is in progress
//
// State table:
//   IDLE    | line silent, waiting for the first mark of a letter
//   MARK    | counting tone units of the current symbol
//   SPACE   | counting silent units after a symbol; LETTER_GAP ends the letter
//   RECOVER | after an error, waiting for LETTER_GAP consecutive zeros
// -----------------------------------------------------------------------------
module morse_decoder
    import morse_pkg::*;
#(
    parameter int LETTER_GAP  = 3,
    parameter int MAX_SYMBOLS = MAX_SYMBOLS_DEF,
    parameter int RUN_W       = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       BitTick,
    input  logic       DotDashIn,
    output logic [2:0] Letter,
    output logic       LetterValid,
    output logic       Error,
    output logic       Busy
);

    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_SAT  = '1;
    localparam logic [RUN_W-1:0] GAP_C    = RUN_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] SYMS_MAX = CNT_W'(MAX_SYMBOLS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
`ifdef MORSE_DEC_TOLERANT_EN
    localparam logic [RUN_W-1:0] MARK_MAX = RUN_W'(4);
`else
    localparam logic [RUN_W-1:0] MARK_MAX = RUN_W'(3);
`endif

    state_t           r_state;
    logic [RUN_W-1:0] r_markcnt;
    logic [RUN_W-1:0] r_spacecnt;
    logic [CNT_W-1:0] r_symcnt;
    logic [SYM_W-1:0] r_symbols;
    letter_t          r_letter;
    logic             r_valid;
    logic             r_error;

    state_t           w_state_nx;
    logic [RUN_W-1:0] w_markcnt_nx;
    logic [RUN_W-1:0] w_spacecnt_nx;
    logic [CNT_W-1:0] w_symcnt_nx;
    logic [SYM_W-1:0] w_symbols_nx;
    letter_t          w_letter_nx;
    logic             w_valid_nx;
    logic             w_error_nx;

    logic [RUN_W-1:0] w_mark_inc;
    logic [RUN_W-1:0] w_space_inc;
    logic [CNT_W-1:0] w_sym_inc;
    logic             w_sym_ok;
    logic             w_sym;
    logic [SYM_W-1:0] w_sym_bit;
    letter_t          w_code;
    logic             w_match;

    morse_pattern_lookup u_lookup (
        .i_symcnt  (r_symcnt),
        .i_symbols (r_symbols),
        .o_code    (w_code),
        .o_match   (w_match)
    );

    assign w_mark_inc  = (r_markcnt  == RUN_SAT) ? r_markcnt  : r_markcnt  + RUN_ONE;
    assign w_space_inc = (r_spacecnt == RUN_SAT) ? r_spacecnt : r_spacecnt + RUN_ONE;
    assign w_sym_inc   = (r_symcnt   == CNT_SAT) ? r_symcnt   : r_symcnt   + CNT_ONE;

    // New symbol lands at the next free slot below the MSB.
    assign w_sym_bit = SYM_W'(w_sym) << (SYM_W - 1 - int'(r_symcnt));

    // Classify the mark that just ended.
    always_comb begin
        w_sym_ok = 1'b0;
        w_sym    = SYM_DOT;
        if (r_markcnt == RUN_ONE) begin
            w_sym_ok = 1'b1;
            w_sym    = SYM_DOT;
`ifdef MORSE_DEC_TOLERANT_EN
        end else if (r_markcnt >= RUN_W'(2) && r_markcnt <= RUN_W'(4)) begin
`else
        end else if (r_markcnt == RUN_W'(3)) begin
`endif
            w_sym_ok = 1'b1;
            w_sym    = SYM_DASH;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_markcnt_nx  = r_markcnt;
        w_spacecnt_nx = r_spacecnt;
        w_symcnt_nx   = r_symcnt;
        w_symbols_nx  = r_symbols;
        w_letter_nx   = r_letter;
        w_valid_nx    = 1'b0;
        w_error_nx    = 1'b0;

        if (BitTick) begin
            case (r_state)
                IDLE: begin
                    if (DotDashIn) begin
                        w_state_nx   = MARK;
                        w_markcnt_nx = RUN_ONE;
                    end
                end

                MARK: begin
                    if (DotDashIn) begin
                        if (w_mark_inc > MARK_MAX) begin
                            w_error_nx    = 1'b1;
                            w_state_nx    = RECOVER;
                            w_spacecnt_nx = '0;
                            w_markcnt_nx  = '0;
                            w_symcnt_nx   = '0;
                            w_symbols_nx  = '0;
                        end else begin
                            w_markcnt_nx = w_mark_inc;
                        end
                    end else if (w_sym_ok) begin
                        w_symbols_nx  = r_symbols | w_sym_bit;
                        w_symcnt_nx   = w_sym_inc;
                        w_markcnt_nx  = '0;
                        w_spacecnt_nx = RUN_ONE;
                        w_state_nx    = SPACE;
                    end else begin
                        // The zero that ended the bad mark counts toward recovery.
                        w_error_nx    = 1'b1;
                        w_state_nx    = RECOVER;
                        w_spacecnt_nx = RUN_ONE;
                        w_markcnt_nx  = '0;
                        w_symcnt_nx   = '0;
                        w_symbols_nx  = '0;
                    end
                end

                SPACE: begin
                    if (DotDashIn) begin
                        if (r_symcnt == SYMS_MAX) begin
                            w_error_nx    = 1'b1;
                            w_state_nx    = RECOVER;
                            w_spacecnt_nx = '0;
                            w_symcnt_nx   = '0;
                            w_symbols_nx  = '0;
                        end else begin
                            w_state_nx   = MARK;
                            w_markcnt_nx = RUN_ONE;
                        end
                    end else if (w_space_inc >= GAP_C) begin
                        if (w_match) begin
                            w_letter_nx = w_code;
                            w_valid_nx  = 1'b1;
                        end else begin
                            w_error_nx = 1'b1;
                        end
                        w_state_nx    = IDLE;
                        w_spacecnt_nx = '0;
                        w_symcnt_nx   = '0;
                        w_symbols_nx  = '0;
                    end else begin
                        w_spacecnt_nx = w_space_inc;
                    end
                end

                RECOVER: begin
                    if (DotDashIn) begin
                        w_spacecnt_nx = '0;
                    end else if (w_space_inc >= GAP_C) begin
                        w_state_nx    = IDLE;
                        w_spacecnt_nx = '0;
                    end else begin
                        w_spacecnt_nx = w_space_inc;
                    end
                end

                default: begin
                    w_state_nx    = IDLE;
                    w_markcnt_nx  = '0;
                    w_spacecnt_nx = '0;
                    w_symcnt_nx   = '0;
                    w_symbols_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_markcnt  <= '0;
            r_spacecnt <= '0;
            r_symcnt   <= '0;
            r_symbols  <= '0;
            r_letter   <= LTR_A;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_markcnt  <= w_markcnt_nx;
            r_spacecnt <= w_spacecnt_nx;
            r_symcnt   <= w_symcnt_nx;
            r_symbols  <= w_symbols_nx;
            r_letter   <= w_letter_nx;
            r_valid    <= w_valid_nx;
            r_error    <= w_error_nx;
        end
    end

    assign Letter      = r_letter;
    assign LetterValid = r_valid;
    assign Error       = r_error;
    assign Busy        = (r_state != IDLE);

endmodule
